uart_tx_scheduler: RTL and testbench

Two-requester scheduler and sequencer in front of the UART byte sender. It arbitrates round-robin between two byte sources and supports multi-byte packets, where a requester holds the channel until its last byte. It presents one byte at a time on the sender's `data_in`/`time025` pins and enforces a guard interval, so a new byte is never launched while the sender's shift frame is still in progress.

---
 rtl/uart_tx_scheduler.sv | 77 +++++++
 tb/tb_uart_tx_scheduler.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/uart_tx_scheduler.sv
// uart_tx_scheduler: two-requester round-robin byte scheduler with packet lock and guard interval for the UART sender
module uart_tx_scheduler #(
  parameter int GUARD_CYCLES = 16
) (
  input  logic       clk_in,
  input  logic       reset,
  input  logic       tx_enable,
  input  logic       req0,
  input  logic       req1,
  input  logic [7:0] data0,
  input  logic [7:0] data1,
  input  logic       last0,
  input  logic       last1,
  output logic       ack0,
  output logic       ack1,
  output logic       tx_start,
  output logic [7:0] tx_data,
  output logic       busy,
  output logic       grant_id
);
  typedef enum logic [1:0] {IDLE, LAUNCH, HOLD} state_t;
  state_t     state;
  logic       lock, lock_id, rr_last;
  logic [7:0] count;
  logic       elig0, elig1, sel;
  always_comb begin
    elig0 = req0 & (~lock | ~lock_id);
    elig1 = req1 & (~lock | lock_id);
    sel   = (elig0 & elig1) ? ~rr_last : elig1;
  end
  always_ff @(posedge clk_in) begin
    if (!reset) begin
      state    <= IDLE;
      lock     <= 1'b0;
      lock_id  <= 1'b0;
      rr_last  <= 1'b1;
      count    <= 8'd0;
      ack0     <= 1'b0;
      ack1     <= 1'b0;
      tx_start <= 1'b0;
      tx_data  <= 8'h00;
      busy     <= 1'b0;
      grant_id <= 1'b0;
    end else begin
      ack0     <= 1'b0;
      ack1     <= 1'b0;
      tx_start <= 1'b0;
      case (state)
        IDLE: if (tx_enable && (elig0 || elig1)) begin
          state    <= LAUNCH;
          tx_data  <= sel ? data1 : data0;
          ack0     <= ~sel;
          ack1     <= sel;
          grant_id <= sel;
          rr_last  <= sel;
          busy     <= 1'b1;
          lock     <= ~(sel ? last1 : last0);
          lock_id  <= sel;
        end
        LAUNCH: begin
          state    <= HOLD;
          tx_start <= 1'b1;
          count    <= 8'(GUARD_CYCLES);
        end
        HOLD: begin
          // Guard spans the launch cycle plus GUARD_CYCLES, so busy drops GUARD_CYCLES+2 after grant
          if (count == 8'd0) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else
            count <= count - 8'd1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_tx_scheduler.sv
// tb_uart_tx_scheduler: randomized bench checking every cycle against a grant-time arithmetic model
module tb_uart_tx_scheduler;
  localparam int G = 16;
  logic       clk_in = 1'b0;
  logic       reset = 1'b0, tx_enable = 1'b1;
  logic       req0 = 1'b0, req1 = 1'b0, last0 = 1'b0, last1 = 1'b0;
  logic [7:0] data0 = 8'h00, data1 = 8'h00;
  logic       ack0, ack1, tx_start, busy, grant_id;
  logic [7:0] tx_data;
  uart_tx_scheduler #(.GUARD_CYCLES(G)) dut (
    .clk_in(clk_in), .reset(reset), .tx_enable(tx_enable),
    .req0(req0), .req1(req1), .data0(data0), .data1(data1),
    .last0(last0), .last1(last1), .ack0(ack0), .ack1(ack1),
    .tx_start(tx_start), .tx_data(tx_data), .busy(busy), .grant_id(grant_id)
  );
  always #5 clk_in = ~clk_in;
  int n_cmp = 0, n_err = 0;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  logic [8:0] q0[$], q1[$];
  logic [7:0] launched[$];
  bit pause0 = 0, pause1 = 0;
  always begin
    @(posedge clk_in);
    #1;
    if (ack0 && q0.size() > 0) void'(q0.pop_front());
    if (ack1 && q1.size() > 0) void'(q1.pop_front());
    req0 = q0.size() > 0 && !pause0;
    req1 = q1.size() > 0 && !pause1;
    if (q0.size() > 0) {last0, data0} = q0[0];
    if (q1.size() > 0) {last1, data1} = q1[0];
  end
  int cyc = 0, g = -1000, rdy = 0;
  bit armed = 0, lk = 0, lid = 0, rr = 1, e0, e1, s;
  logic ea0 = 0, ea1 = 0, es = 0, eb = 0, eg = 0;
  logic [7:0] ed = 8'h00;
  always @(posedge clk_in) begin
    cyc++;
    armed = 1;
    if (!reset) begin
      lk = 0; lid = 0; rr = 1; g = -1000; rdy = cyc + 1;
      ea0 = 0; ea1 = 0; ed = 8'h00; eg = 0;
    end else begin
      ea0 = 0; ea1 = 0;
      e0 = req0 && (!lk || !lid);
      e1 = req1 && (!lk || lid);
      if (cyc >= rdy && tx_enable && (e0 || e1)) begin
        s = (e0 && e1) ? !rr : e1;
        ea0 = !s; ea1 = s;
        ed = s ? data1 : data0;
        eg = s; rr = s; lid = s;
        lk = !(s ? last1 : last0);
        g = cyc;
        rdy = cyc + G + 3;
      end
    end
    es = (cyc == g + 1);
    eb = (cyc >= g && cyc < g + G + 2);
  end
  always @(negedge clk_in) if (armed) begin
    check("ack0", ack0, ea0);
    check("ack1", ack1, ea1);
    check("tx_start", tx_start, es);
    check("tx_data", tx_data, ed);
    check("busy", busy, eb);
    check("grant_id", grant_id, eg);
    if (tx_start) launched.push_back(tx_data);
  end
  task automatic cycles(input int n);
    repeat (n) @(posedge clk_in);
    #1;
  endtask
  task automatic push_pkt(input bit which);
    int len = $urandom_range(1, 4);
    for (int i = 0; i < len; i++) begin
      logic [8:0] e = {i == len - 1, 8'($urandom)};
      if (which) q1.push_back(e); else q0.push_back(e);
    end
  endtask
  task automatic wait_start(input string tag);
    bit seen = 0;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(negedge clk_in);
      seen = tx_start;
    end
    check(tag, seen, 1'b1);
    @(posedge clk_in);
    #1;
  endtask
  initial begin
    logic [7:0] exp_rr[4], exp_lk[4];
    exp_rr[0] = 8'h11; exp_rr[1] = 8'h22; exp_rr[2] = 8'h11; exp_rr[3] = 8'h22;
    exp_lk[0] = 8'h01; exp_lk[1] = 8'h02; exp_lk[2] = 8'h03; exp_lk[3] = 8'h55;
    repeat (2) begin q0.push_back({1'b1, 8'h11}); q1.push_back({1'b1, 8'h22}); end
    cycles(4);
    reset = 1'b1;
    launched.delete();
    cycles(90);
    check("rr_count", launched.size(), 4);
    for (int i = 0; i < 4; i++) if (i < launched.size()) check("rr_seq", launched[i], exp_rr[i]);
    launched.delete();
    q1.push_back({1'b1, 8'h55});
    q0.push_back({1'b0, 8'h01}); q0.push_back({1'b0, 8'h02}); q0.push_back({1'b1, 8'h03});
    cycles(100);
    check("lock_count", launched.size(), 4);
    for (int i = 0; i < 4; i++) if (i < launched.size()) check("lock_seq", launched[i], exp_lk[i]);
    repeat (3) q0.push_back({1'b1, 8'h3C});
    wait_start("gate_start");
    tx_enable = 1'b0;
    cycles(60);
    check("gate_busy", busy, 1'b0);
    tx_enable = 1'b1;
    cycles(80);
    q0.push_back({1'b0, 8'hA0}); q0.push_back({1'b0, 8'hA1}); q0.push_back({1'b1, 8'hA2});
    q1.push_back({1'b1, 8'hB0});
    wait_start("rst_start");
    cycles(10);
    reset = 1'b0;
    cycles(1);
    check("rst_busy", busy, 1'b0);
    reset = 1'b1;
    cycles(120);
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 19) == 0 && q0.size() < 6) push_pkt(0);
      if ($urandom_range(0, 19) == 0 && q1.size() < 6) push_pkt(1);
      tx_enable = $urandom_range(0, 9) != 0;
      pause0 = $urandom_range(0, 15) == 0;
      pause1 = $urandom_range(0, 15) == 0;
      reset = $urandom_range(0, 499) != 0;
      cycles(1);
    end
    reset = 1'b1; tx_enable = 1'b1; pause0 = 0; pause1 = 0;
    cycles(200);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
